// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants: FSM states, line levels, baud divisor
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_e;

  localparam logic UART_STOP_BIT  = 1'b1;
  localparam logic UART_START_BIT = 1'b0;

  function automatic int uart_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - DEPTH x 8 byte queue, wrap-bit pointers, push accepted when full if popped same cycle
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]  mem_q [DEPTH];
  logic        push_ok, pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // When full with a simultaneous pop, the head is read before this write lands on its slot.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - buffered 8N1 UART transmitter; UART_TX_PARITY_EN adds an even-parity bit (8E1)
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       wr,
  input  logic [7:0] tx_data,
  output logic       full,
  output logic       busy,
  output logic       ovf,
  output logic       o_serial_data
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sr_q, sr_d;
  logic          line_q, line_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic          pop, load, bit_done;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetq (resetq),
    .push   (wr),
    .pop    (pop),
    .din    (tx_data),
    .dout   (fifo_dout),
    .full   (full),
    .empty  (fifo_empty)
  );

  assign bit_done = (baud_q == '0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    line_d  = UART_STOP_BIT;
    load    = 1'b0;
    pop     = 1'b0;
    if (!bit_done) baud_d = baud_q - 1'b1;
    case (state_q)
      S_IDLE: load = ~fifo_empty;
      S_START: begin
        line_d = UART_START_BIT;
        if (bit_done) begin
          baud_d  = BAUD_LAST;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        line_d = sr_q[0];
        if (bit_done) begin
          baud_d = BAUD_LAST;
          sr_d   = {1'b0, sr_q[7:1]};
          bit_d  = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        line_d = par_q;
        if (bit_done) begin
          baud_d  = BAUD_LAST;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Last stop clock chains straight into the next queued frame.
        if (bit_done) begin
          load    = ~fifo_empty;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      pop     = 1'b1;
      sr_d    = fifo_dout;
      baud_d  = BAUD_LAST;
      bit_d   = '0;
      state_d = S_START;
    end
  end

  assign busy_d = wr | ~fifo_empty | (state_d != S_IDLE);
  assign ovf_d  = ovf_q | (wr & full & ~pop);
`ifdef UART_TX_PARITY_EN
  assign par_d  = load ? ^fifo_dout : par_q;
`endif

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      line_q  <= UART_STOP_BIT;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign o_serial_data = line_q;
  assign busy          = busy_q;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed self-checking bench for uart_tx_serializer at DIV=16
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * DIV;

  logic       clk = 1'b0;
  logic       resetq = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       full, busy, ovf, o_serial_data;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          t0, t_wr, seen;
  logic [31:0] bits;
  logic [31:0] fb [6];
  int          ts [6];

  uart_tx_serializer #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .resetq        (resetq),
    .wr            (wr),
    .tx_data       (tx_data),
    .full          (full),
    .busy          (busy),
    .ovf           (ovf),
    .o_serial_data (o_serial_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line bits in time order, bit 0 = start bit.
  function automatic logic [31:0] exp_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {21'd0, 1'b1, ^b, b, 1'b0};
`else
    return {22'd0, 1'b1, b, 1'b0};
`endif
  endfunction

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    wr = 1'b1;
    tx_data = b;
  endtask

  task automatic put_end();
    @(negedge clk);
    wr = 1'b0;
    tx_data = 8'h00;
  endtask

  task automatic rx_frame(output logic [31:0] fbits, output int tstart);
    int n;
    n = 0;
    fbits = '0;
    tstart = -1;
    do begin
      @(negedge clk);
      n++;
    end while (o_serial_data !== 1'b0 && n < 400);
    if (o_serial_data !== 1'b0) begin
      chk_eq("start_timeout", 32'(o_serial_data), 32'd0);
      return;
    end
    tstart = cyc;
    repeat (DIV / 2) @(negedge clk);
    fbits[0] = o_serial_data;
    for (int i = 1; i < NB; i++) begin
      repeat (DIV) @(negedge clk);
      fbits[i] = o_serial_data;
    end
  endtask

  initial begin
    // reset held with write pulses
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr = i[0];
      tx_data = 8'h5a;
      @(negedge clk);
      chk_eq("reset_state", 32'({o_serial_data, busy, full, ovf}), 32'b1000);
    end
    wr = 1'b0;
    @(negedge clk);
    resetq = 1'b1;
    repeat (3) @(negedge clk);

    // single byte
    put(8'h1b);
    put_end();
    t_wr = cyc;
    chk_eq("busy_after_wr", 32'(busy), 32'd1);
    rx_frame(bits, t0);
    chk_eq("start_latency", 32'(t0 - t_wr), 32'd2);
    chk_eq("frame_1b", bits, exp_frame(8'h1b));
    chk_eq("busy_in_stop", 32'(busy), 32'd1);
    repeat (12) @(negedge clk);
    chk_eq("idle_after_1b", 32'({busy, o_serial_data}), 32'b01);

    // four-byte burst, back to back
    fork
      begin
        put(8'h41); put(8'h42); put(8'h43); put(8'h44);
        put_end();
      end
      begin
        for (int k = 0; k < 4; k++) rx_frame(fb[k], ts[k]);
      end
    join
    for (int k = 0; k < 4; k++) chk_eq("burst_frame", fb[k], exp_frame(8'h41 + 8'(k)));
    for (int k = 1; k < 4; k++) chk_eq("burst_gap", 32'(ts[k] - ts[k-1]), 32'(FRAME));
    chk_eq("burst_ovf", 32'(ovf), 32'd0);
    repeat (20) @(negedge clk);

    // fill, push on the pop cycle while full, then overflow
    fork
      begin
        put(8'h10); put(8'h20); put(8'h30); put(8'h40); put(8'h50);
        put_end();
        chk_eq("full_after_fill", 32'(full), 32'd1);
        chk_eq("ovf_after_fill", 32'(ovf), 32'd0);
      end
      rx_frame(fb[0], ts[0]);
    join
    while (cyc < ts[0] + FRAME - 2) @(negedge clk);
    chk_eq("full_before_pop", 32'(full), 32'd1);
    fork
      begin
        wr = 1'b1;
        tx_data = 8'h3c;
        @(negedge clk);
        wr = 1'b0;
        chk_eq("full_push_pop", 32'(full), 32'd1);
        chk_eq("ovf_push_pop", 32'(ovf), 32'd0);
        put(8'hff);
        put_end();
        chk_eq("ovf_set", 32'(ovf), 32'd1);
      end
      begin
        for (int k = 1; k < 6; k++) rx_frame(fb[k], ts[k]);
      end
    join
    chk_eq("fill_frame0", fb[0], exp_frame(8'h10));
    chk_eq("fill_frame1", fb[1], exp_frame(8'h20));
    chk_eq("fill_frame4", fb[4], exp_frame(8'h50));
    chk_eq("pushpop_frame", fb[5], exp_frame(8'h3c));
    chk_eq("fill_gap", 32'(ts[1] - ts[0]), 32'(FRAME));
    seen = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (o_serial_data === 1'b0) seen = 1;
    end
    chk_eq("no_ff_frame", 32'(seen), 32'd0);
    chk_eq("ovf_sticky", 32'({ovf, full, busy}), 32'b100);

    // mid-frame reset
    put(8'h55);
    put_end();
    t_wr = cyc;
    while (cyc < t_wr + 2 + 4 * DIV + DIV / 2) @(negedge clk);
    chk_eq("bit3_of_55", 32'(o_serial_data), 32'd0);
    #2 resetq = 1'b0;
    #1;
    chk_eq("async_rst_line", 32'(o_serial_data), 32'd1);
    chk_eq("async_rst_flags", 32'({busy, full, ovf}), 32'b000);
    repeat (3) @(negedge clk);
    resetq = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (o_serial_data === 1'b0) seen = 1;
    end
    chk_eq("no_frame_after_rst", 32'(seen), 32'd0);
    put(8'ha5);
    put_end();
    t_wr = cyc;
    rx_frame(bits, t0);
    chk_eq("start_latency_a5", 32'(t0 - t_wr), 32'd2);
    chk_eq("frame_a5", bits, exp_frame(8'ha5));
    repeat (12) @(negedge clk);
    chk_eq("idle_after_a5", 32'({busy, o_serial_data}), 32'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
